code_lock_ctrl: RTL and testbench
=================================

Name: code_lock_ctrl

Overview:
- Parametrised keypad code lock controller; next generation of the team's single-output electronic lock.
- Generalised code length and digit width.
- Adds over the previous lock: full-code comparison with no early reject, a wrong-attempt counter with timed lockout, atomic passcode reprogramming with cancel, and status outputs.
- Sits between the keypad decoder (valid-strobed digits and commands) and the actuator driver / status LEDs.

Parameters:
- CODE_LEN, 4, number of digits per code (>=1).
- DIGIT_W, 4, bits per digit.
- MAX_TRIES, 3, consecutive wrong codes that trigger lockout (>=1).
- UNLOCK_CYCLES, 10_000_000, cycles the lock stays open (>=1).
- LOCKOUT_CYCLES, 50_000_000, cycles of lockout (>=1).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous and active-high.
- digit_valid  in  1  one-cycle strobe: digit is a keypress.
- digit  in  DIGIT_W  digit value; sampled only when digit_valid=1.
- cmd_cancel  in  1  one-cycle strobe: abort current entry or programming.
- cmd_set  in  1  one-cycle strobe: enter programming (UNLOCKED only).
- unlocked  out  1  lock open.
- lockout  out  1  lockout active.
- set_mode  out  1  programming in progress.
- err_pulse  out  1  one-cycle pulse on each wrong full code.
- digit_idx  out  $clog2(CODE_LEN+1)  digits entered in current entry/programming.
- fail_count  out  $clog2(MAX_TRIES+1)  consecutive wrong codes.

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-entry/programming/timers):
  - state ENTRY; stored code all zeros; shadow code, timers, digit_idx and fail_count = 0.
  - All outputs 0 from the following cycle.
- All outputs are registered.
- Input priority in the same cycle: cmd_cancel > cmd_set > digit_valid.
- ENTRY:
  - Each digit_valid writes into an entry buffer at digit_idx, then digit_idx increments.
  - No per-digit verdict is given.
  - On the CODE_LEN-th digit, the full buffer (including that digit) is compared with the stored code.
  - Match: go to UNLOCKED; fail_count cleared; unlocked=1 on the cycle after the last digit's strobe edge.
  - Mismatch: err_pulse=1 for exactly one cycle (same latency); fail_count increments.
  - If fail_count reaches MAX_TRIES, go to LOCKOUT in the same transition.
  - Either way digit_idx returns to 0.
  - cmd_cancel clears digit_idx; fail_count is unchanged; no error is raised.
  - cmd_set is ignored.
- UNLOCKED:
  - Timer loads UNLOCK_CYCLES; unlocked stays high exactly UNLOCK_CYCLES cycles, then state returns to ENTRY.
  - digit_valid is ignored.
  - cmd_cancel closes the lock immediately (next cycle unlocked=0, ENTRY).
  - cmd_set goes to SET: unlocked=0 and set_mode=1 from the next cycle; timer stops.
- SET:
  - Each digit_valid writes into the shadow code; digit_idx increments.
  - The CODE_LEN-th digit commits shadow (including that digit) to the stored code in one cycle, atomically; then ENTRY, set_mode=0.
  - cmd_cancel discards the shadow; stored code is unchanged; go to ENTRY.
  - No timeout in SET.
- LOCKOUT:
  - lockout=1 for exactly LOCKOUT_CYCLES cycles.
  - All inputs are ignored, including cmd_cancel.
  - On expiry: fail_count=0, ENTRY.
- Timers use a single down-counter of width $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1).
  - Terminal count is detected at 1; the counter never wraps.
- State encoding is one-hot-safe; unreachable encodings recover to ENTRY on the next cycle.
- Digit values are unrestricted: all 2^DIGIT_W values are legal code digits. There are no reserved codes.
- Only one output among unlocked, lockout, set_mode is high at any time.

Test Plan (CODE_LEN=4, DIGIT_W=4, MAX_TRIES=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16):
1. After reset, enter 0,0,0,0 -> unlocked=1 the cycle after the 4th strobe, held exactly 8 cycles, then 0; fail_count=0.
2. Program: unlock, cmd_set, digits 3,7,1,9 -> set_mode high during entry, drops after 9. Then 0,0,0,0 -> err_pulse once, fail_count=1. Then 3,7,1,9 -> unlocked=1, fail_count=0.
3. Three wrong codes (5,5,5,5 x3) -> err_pulse x3, lockout=1 for 16 cycles. During lockout the correct code and cmd_cancel have no effect. Afterwards fail_count=0 and the correct code unlocks.
4. Program 1,2 then cmd_cancel -> set_mode=0, stored code unchanged (old code still unlocks).
5. Entry 0,0 then cmd_cancel, then 0,0,0,0 -> unlocks. Same cycle cmd_cancel+digit_valid: cancel wins, digit_idx=0.
6. rst asserted mid-unlock (cycle 4) and mid-lockout -> next cycle all outputs 0, stored code back to 0,0,0,0.

Source files
------------

// File: rtl/code_lock_ctrl.sv
// -----------------------------------------------------------------------------
// code_lock_ctrl
//
// Keypad code lock controller. It collects valid-strobed digits from the
// keypad decoder and compares a complete code against the stored passcode.
// There is no early reject: the verdict comes only after all digits are in.
// Consecutive wrong codes are counted, and reaching the limit starts a timed
// lockout. While the lock is open the passcode can be reprogrammed. The new
// code is committed atomically on its last digit, and the change can be
// cancelled before then.
//
// Ports:
//   clk         in   clock, single domain
//   rst         in   synchronous active-high reset
//   digit_valid in   one-cycle strobe, digit holds a keypress
//   digit       in   [DIGIT_W] digit value, sampled only with digit_valid
//   cmd_cancel  in   one-cycle strobe, abort entry / programming / open lock
//   cmd_set     in   one-cycle strobe, start programming (only while open)
//   unlocked    out  lock open
//   lockout     out  lockout active
//   set_mode    out  programming in progress
//   err_pulse   out  one-cycle pulse on each wrong full code
//   digit_idx   out  [IDX_W] digits entered in current entry / programming
//   fail_count  out  [FC_W] consecutive wrong codes
//
// Every output is a flop. Same-cycle priority: cmd_cancel > cmd_set > digit_valid.
// -----------------------------------------------------------------------------
module code_lock_ctrl #(
    parameter int CODE_LEN       = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 10_000_000,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    localparam int IDX_W         = $clog2(CODE_LEN + 1),
    localparam int FC_W          = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               cmd_cancel,
    input  logic               cmd_set,
    output logic               unlocked,
    output logic               lockout,
    output logic               set_mode,
    output logic               err_pulse,
    output logic [IDX_W-1:0]   digit_idx,
    output logic [FC_W-1:0]    fail_count
);

    localparam int MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int CODE_W  = CODE_LEN * DIGIT_W;

    // One-hot state encoding. Any other pattern falls to the default branch.
    localparam logic [3:0] S_ENTRY    = 4'b0001;
    localparam logic [3:0] S_UNLOCKED = 4'b0010;
    localparam logic [3:0] S_SET      = 4'b0100;
    localparam logic [3:0] S_LOCKOUT  = 4'b1000;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FC_LIMIT     = FC_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);

    logic [3:0]        state_q,      state_d;
    logic [CODE_W-1:0] stored_q,     stored_d;
    // Entry digits and the programming shadow code are never live at the same
    // time, so a single buffer holds both.
    logic [CODE_W-1:0] buf_q,        buf_d;
    logic [TMR_W-1:0]  timer_q,      timer_d;
    logic [IDX_W-1:0]  digit_idx_q,  digit_idx_d;
    logic [FC_W-1:0]   fail_count_q, fail_count_d;
    logic              unlocked_q,   unlocked_d;
    logic              lockout_q,    lockout_d;
    logic              set_mode_q,   set_mode_d;
    logic              err_pulse_q,  err_pulse_d;

    logic [CODE_W-1:0] buf_full;
    logic [FC_W-1:0]   fail_inc;
    logic              last_digit;
    logic              timer_done;

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        // Buffer with the current keypress inserted. This lets the final digit
        // be compared and committed in the same cycle it arrives.
        buf_full = buf_q;
        buf_full[int'(digit_idx_q) * DIGIT_W +: DIGIT_W] = digit;
        fail_inc   = fail_count_q + FC_W'(1);
        last_digit = (digit_idx_q == LAST_IDX);
        // The terminal count is 1. A value of 0 also counts as done, so the
        // timer can never wrap.
        timer_done = (timer_q <= TMR_ONE);
    end

    always_comb begin
        state_d      = state_q;
        stored_d     = stored_q;
        buf_d        = buf_q;
        timer_d      = timer_q;
        digit_idx_d  = digit_idx_q;
        fail_count_d = fail_count_q;
        err_pulse_d  = 1'b0;

        case (state_q)
            S_ENTRY: begin
                timer_d = '0;
                if (cmd_cancel) begin
                    digit_idx_d = '0;
                end else if (cmd_set) begin
                    // Programming is only reachable from an open lock.
                end else if (digit_valid) begin
                    buf_d = buf_full;
                    if (last_digit) begin
                        digit_idx_d = '0;
                        if (buf_full == stored_q) begin
                            state_d      = S_UNLOCKED;
                            timer_d      = UNLOCK_LOAD;
                            fail_count_d = '0;
                        end else begin
                            err_pulse_d  = 1'b1;
                            fail_count_d = fail_inc;
                            if (fail_inc == FC_LIMIT) begin
                                state_d = S_LOCKOUT;
                                timer_d = LOCKOUT_LOAD;
                            end
                        end
                    end else begin
                        digit_idx_d = digit_idx_q + IDX_W'(1);
                    end
                end
            end

            S_UNLOCKED: begin
                if (cmd_cancel) begin
                    state_d = S_ENTRY;
                    timer_d = '0;
                end else if (cmd_set) begin
                    state_d     = S_SET;
                    timer_d     = '0;
                    digit_idx_d = '0;
                    buf_d       = '0;
                end else if (timer_done) begin
                    state_d = S_ENTRY;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end

            S_SET: begin
                timer_d = '0;
                if (cmd_cancel) begin
                    state_d     = S_ENTRY;
                    digit_idx_d = '0;
                    buf_d       = '0;
                end else if (cmd_set) begin
                    // Already programming.
                end else if (digit_valid) begin
                    buf_d = buf_full;
                    if (last_digit) begin
                        stored_d    = buf_full;
                        state_d     = S_ENTRY;
                        digit_idx_d = '0;
                    end else begin
                        digit_idx_d = digit_idx_q + IDX_W'(1);
                    end
                end
            end

            S_LOCKOUT: begin
                // Deaf to every input until the timer expires.
                if (timer_done) begin
                    state_d      = S_ENTRY;
                    timer_d      = '0;
                    fail_count_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end

            default: begin
                state_d     = S_ENTRY;
                timer_d     = '0;
                digit_idx_d = '0;
            end
        endcase

        // Status flags come from the next state, so they appear as registered
        // outputs one cycle after the deciding edge. Only one can be high.
        unlocked_d = (state_d == S_UNLOCKED);
        lockout_d  = (state_d == S_LOCKOUT);
        set_mode_d = (state_d == S_SET);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ENTRY;
            // NOTE: the code registers are ordinary flops, not a RAM, so they
            // take the reset; the stored code must return to all zeros.
            stored_q     <= '0;
            buf_q        <= '0;
            timer_q      <= '0;
            digit_idx_q  <= '0;
            fail_count_q <= '0;
            unlocked_q   <= 1'b0;
            lockout_q    <= 1'b0;
            set_mode_q   <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stored_q     <= stored_d;
            buf_q        <= buf_d;
            timer_q      <= timer_d;
            digit_idx_q  <= digit_idx_d;
            fail_count_q <= fail_count_d;
            unlocked_q   <= unlocked_d;
            lockout_q    <= lockout_d;
            set_mode_q   <= set_mode_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign unlocked   = unlocked_q;
    assign lockout    = lockout_q;
    assign set_mode   = set_mode_q;
    assign err_pulse  = err_pulse_q;
    assign digit_idx  = digit_idx_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_code_lock_ctrl
//
// Scoreboard bench for code_lock_ctrl with short timers. A reference model
// tracks the mode, the typed digits, the stored code, the remaining open or
// lockout time and the failure count. After each clock edge the stimulus side
// pushes the expected output set. A monitor pops it on the falling edge and
// compares it with the DUT outputs. Directed scenarios come first, followed by
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_code_lock_ctrl;

    localparam int CODE_LEN = 4;
    localparam int DIGIT_W  = 4;
    localparam int MAX_TRY  = 3;
    localparam int OPEN_CYC = 8;
    localparam int LOCK_CYC = 16;
    localparam int IDX_W    = $clog2(CODE_LEN + 1);
    localparam int FC_W     = $clog2(MAX_TRY + 1);

    typedef struct packed {
        logic             unlocked;
        logic             lockout;
        logic             set_mode;
        logic             err;
        logic [IDX_W-1:0] idx;
        logic [FC_W-1:0]  fc;
    } out_t;

    typedef enum {M_ENTRY, M_OPEN, M_SET, M_LOCK} mode_e;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               digit_valid = 1'b0;
    logic [DIGIT_W-1:0] digit = '0;
    logic               cmd_cancel = 1'b0;
    logic               cmd_set = 1'b0;
    logic               unlocked, lockout, set_mode, err_pulse;
    logic [IDX_W-1:0]   digit_idx;
    logic [FC_W-1:0]    fail_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    out_t exp_q[$];

    // Reference model state.
    mode_e mode = M_ENTRY;
    int    stored[CODE_LEN];
    int    typed[$];
    int    remaining = 0;
    int    fails = 0;
    bit    m_err = 1'b0;

    code_lock_ctrl #(
        .CODE_LEN       (CODE_LEN),
        .DIGIT_W        (DIGIT_W),
        .MAX_TRIES      (MAX_TRY),
        .UNLOCK_CYCLES  (OPEN_CYC),
        .LOCKOUT_CYCLES (LOCK_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .cmd_cancel  (cmd_cancel),
        .cmd_set     (cmd_set),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .set_mode    (set_mode),
        .err_pulse   (err_pulse),
        .digit_idx   (digit_idx),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got unl=%0b lko=%0b set=%0b err=%0b idx=%0d fc=%0d, want unl=%0b lko=%0b set=%0b err=%0b idx=%0d fc=%0d",
                     name, act.unlocked, act.lockout, act.set_mode, act.err, act.idx, act.fc,
                     exp.unlocked, exp.lockout, exp.set_mode, exp.err, exp.idx, exp.fc);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every edge.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            out_t e;
            out_t a;
            e = exp_q.pop_front();
            a = '{unlocked, lockout, set_mode, err_pulse, digit_idx, fail_count};
            check($sformatf("cycle %0d", cyc), a, e);
        end
    end

    // Behavioural model, applied once per clock edge.
    task automatic model_step(input bit r, input bit c, input bit s, input bit v, input int d);
        m_err = 1'b0;
        if (r) begin
            mode = M_ENTRY;
            typed.delete();
            foreach (stored[i]) stored[i] = 0;
            remaining = 0;
            fails = 0;
            return;
        end
        case (mode)
            M_ENTRY: begin
                if (c) typed.delete();
                else if (!s && v) begin
                    typed.push_back(d);
                    if (typed.size() == CODE_LEN) begin
                        bit ok;
                        ok = 1'b1;
                        foreach (stored[i]) if (typed[i] != stored[i]) ok = 1'b0;
                        typed.delete();
                        if (ok) begin
                            mode = M_OPEN;
                            remaining = OPEN_CYC;
                            fails = 0;
                        end else begin
                            m_err = 1'b1;
                            fails++;
                            if (fails == MAX_TRY) begin
                                mode = M_LOCK;
                                remaining = LOCK_CYC;
                            end
                        end
                    end
                end
            end
            M_OPEN: begin
                if (c) mode = M_ENTRY;
                else if (s) mode = M_SET;
                else begin
                    remaining--;
                    if (remaining == 0) mode = M_ENTRY;
                end
            end
            M_SET: begin
                if (c) begin
                    typed.delete();
                    mode = M_ENTRY;
                end else if (!s && v) begin
                    typed.push_back(d);
                    if (typed.size() == CODE_LEN) begin
                        foreach (stored[i]) stored[i] = typed[i];
                        typed.delete();
                        mode = M_ENTRY;
                    end
                end
            end
            M_LOCK: begin
                remaining--;
                if (remaining == 0) begin
                    fails = 0;
                    mode = M_ENTRY;
                end
            end
            default: mode = M_ENTRY;
        endcase
    endtask

    function automatic out_t model_out();
        out_t o;
        o.unlocked = (mode == M_OPEN);
        o.lockout  = (mode == M_LOCK);
        o.set_mode = (mode == M_SET);
        o.err      = m_err;
        o.idx      = IDX_W'(typed.size());
        o.fc       = FC_W'(fails);
        return o;
    endfunction

    // One clock of stimulus: drive after the falling edge, then record the
    // expected outputs once the rising edge has happened.
    task automatic step(input bit r, input bit c, input bit s, input bit v, input int d);
        @(negedge clk);
        rst = r;
        cmd_cancel = c;
        cmd_set = s;
        digit_valid = v;
        digit = DIGIT_W'(d);
        model_step(r, c, s, v, d);
        @(posedge clk);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic key(input int d);
        step(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic code4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic cancel();
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic set_cmd();
        step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic reset_pulse();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        foreach (stored[i]) stored[i] = 0;
        reset_pulse();
        reset_pulse();
        idle(2);

        // Default code opens, stays open for the full window, then closes.
        code4(0, 0, 0, 0);
        idle(OPEN_CYC + 2);

        // Reprogram to 3719; the old code now fails and the new one opens.
        code4(0, 0, 0, 0);
        idle(1);
        set_cmd();
        code4(3, 7, 1, 9);
        idle(2);
        code4(0, 0, 0, 0);
        code4(3, 7, 1, 9);
        idle(OPEN_CYC + 2);

        // Three wrong codes trigger lockout; the right code and cancel are ignored.
        code4(5, 5, 5, 5);
        code4(5, 5, 5, 5);
        code4(5, 5, 5, 5);
        code4(3, 7, 1, 9);
        cancel();
        idle(LOCK_CYC);
        code4(3, 7, 1, 9);
        idle(OPEN_CYC + 2);

        // Programming aborted part-way leaves the stored code alone.
        code4(3, 7, 1, 9);
        set_cmd();
        key(1);
        key(2);
        cancel();
        idle(2);
        code4(3, 7, 1, 9);
        cancel();
        idle(2);

        // Partial entry cancel, and cancel beating a same-cycle digit.
        key(3);
        key(7);
        cancel();
        code4(3, 7, 1, 9);
        idle(OPEN_CYC + 1);
        key(3);
        key(7);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1);
        code4(3, 7, 1, 9);
        idle(OPEN_CYC + 1);

        // Reset in the middle of an open window restores the zero code.
        code4(3, 7, 1, 9);
        idle(3);
        reset_pulse();
        code4(0, 0, 0, 0);
        idle(OPEN_CYC + 1);

        // Reset in the middle of lockout.
        code4(5, 5, 5, 5);
        code4(5, 5, 5, 5);
        code4(5, 5, 5, 5);
        idle(5);
        reset_pulse();
        code4(0, 0, 0, 0);
        idle(OPEN_CYC + 1);

        // Randomized traffic: digits often follow the stored code so that
        // opens and reprogramming happen regularly.
        for (int n = 0; n < 4000; n++) begin
            int r;
            int d;
            r = int'($urandom_range(0, 99));
            if (mode == M_ENTRY && $urandom_range(0, 1) == 1)
                d = stored[typed.size()];
            else
                d = int'($urandom_range(0, (1 << DIGIT_W) - 1));
            if (r < 1)       step(1'b1, 1'b0, 1'b0, 1'b0, 0);
            else if (r < 5)  step(1'b0, 1'b1, 1'b0, $urandom_range(0, 1) == 1, d);
            else if (r < 7)  step(1'b0, 1'b1, 1'b1, 1'b0, 0);
            else if (r < 17) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
            else if (r < 75) step(1'b0, 1'b0, 1'b0, 1'b1, d);
            else             idle(1);
        end
        idle(2);

        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
